mem_responder: RTL and testbench

Memory-side responder for the directory's memory interface. It accepts line read requests (`drtomem_req`), masked writebacks (`drtomem_wb`) and prefetch requests (`drtomem_pfreq`). It answers each read request with a full-line ack (`memtodr_ack`) after a fixed latency, served from a small internal line store. It sits below a directory bank, either in the bench or as the memory stand-in for multi-bank bring-up.

---
 rtl/mem_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory stand-in: masked line store answering reads in order, LATENCY-1 timer cycles after accept.
// Ack backpressure holds the head stable; a full queue or a pending writeback retries requests.
module mem_responder #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4,
  parameter int MEM_NID = 0,
  parameter int ACK_VAL = 0,
  parameter int DRID_W  = 6,
  parameter int CMD_W   = 5,
  parameter int PADDR_W = 50,
  parameter int NID_W   = 5,
  parameter int ACK_W   = 3,
  parameter int LINE_W  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drtomem_req_valid,
  output logic               drtomem_req_retry,
  input  logic [DRID_W-1:0]  drtomem_req_drid,
  input  logic [CMD_W-1:0]   drtomem_req_cmd,
  input  logic [PADDR_W-1:0] drtomem_req_paddr,
  output logic               memtodr_ack_valid,
  input  logic               memtodr_ack_retry,
  output logic [DRID_W-1:0]  memtodr_ack_drid,
  output logic [NID_W-1:0]   memtodr_ack_nid,
  output logic [PADDR_W-1:0] memtodr_ack_paddr,
  output logic [ACK_W-1:0]   memtodr_ack_ack,
  output logic [LINE_W-1:0]  memtodr_ack_line_7,
  output logic [LINE_W-1:0]  memtodr_ack_line_6,
  output logic [LINE_W-1:0]  memtodr_ack_line_5,
  output logic [LINE_W-1:0]  memtodr_ack_line_4,
  output logic [LINE_W-1:0]  memtodr_ack_line_3,
  output logic [LINE_W-1:0]  memtodr_ack_line_2,
  output logic [LINE_W-1:0]  memtodr_ack_line_1,
  output logic [LINE_W-1:0]  memtodr_ack_line_0,
  input  logic               drtomem_wb_valid,
  output logic               drtomem_wb_retry,
  input  logic [LINE_W-1:0]  drtomem_wb_line_7,
  input  logic [LINE_W-1:0]  drtomem_wb_line_6,
  input  logic [LINE_W-1:0]  drtomem_wb_line_5,
  input  logic [LINE_W-1:0]  drtomem_wb_line_4,
  input  logic [LINE_W-1:0]  drtomem_wb_line_3,
  input  logic [LINE_W-1:0]  drtomem_wb_line_2,
  input  logic [LINE_W-1:0]  drtomem_wb_line_1,
  input  logic [LINE_W-1:0]  drtomem_wb_line_0,
  input  logic [LINE_W-1:0]  drtomem_wb_mask,
  input  logic [PADDR_W-1:0] drtomem_wb_paddr,
  input  logic               drtomem_pfreq_valid,
  output logic               drtomem_pfreq_retry,
  input  logic [NID_W-1:0]   drtomem_pfreq_nid,
  input  logic [PADDR_W-1:0] drtomem_pfreq_paddr
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int PTR_W     = $clog2(QDEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int TMR_W     = 4;
  localparam int LINE_BITS = 8 * LINE_W;
  localparam int NBYTES    = LINE_BITS / 8;

  typedef struct packed {
    logic [DRID_W-1:0]    drid;
    logic [PADDR_W-1:0]   paddr;
    logic [LINE_BITS-1:0] line;
  } ent_t;

  logic [LINE_BITS-1:0] store [DEPTH];
  ent_t                 q_ent [QDEPTH];
  logic [TMR_W-1:0]     q_tmr [QDEPTH];

  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_nxt;
  logic                 full_q, retry_q;
  logic [NID_W-1:0]     nid_q;
  logic [ACK_W-1:0]     ack_q;

  logic [LINE_BITS-1:0] wb_line;
  logic [IDX_W-1:0]     wb_idx, req_idx;
  logic                 wb_fire, req_fire, ack_fire;
  ent_t                 head, push_ent;
  logic                 unused_inputs;

  assign wb_line = {drtomem_wb_line_7, drtomem_wb_line_6, drtomem_wb_line_5, drtomem_wb_line_4,
                    drtomem_wb_line_3, drtomem_wb_line_2, drtomem_wb_line_1, drtomem_wb_line_0};
  assign wb_idx  = drtomem_wb_paddr[6 +: IDX_W];
  assign req_idx = drtomem_req_paddr[6 +: IDX_W];

  // retry_q is set by reset and cleared on the first edge after it, covering every channel.
  assign drtomem_wb_retry    = retry_q;
  assign drtomem_pfreq_retry = retry_q;
  assign drtomem_req_retry   = retry_q | full_q | drtomem_wb_valid;

  assign wb_fire  = drtomem_wb_valid & ~retry_q;
  assign req_fire = drtomem_req_valid & ~drtomem_req_retry;

  assign head              = q_ent[rd_ptr];
  assign memtodr_ack_valid = (count != '0) & (q_tmr[rd_ptr] == '0);
  assign ack_fire          = memtodr_ack_valid & ~memtodr_ack_retry;

  assign push_ent.drid  = drtomem_req_drid;
  assign push_ent.paddr = drtomem_req_paddr;
  assign push_ent.line  = store[req_idx];

  always_comb begin
    count_nxt = count;
    case ({req_fire, ack_fire})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (wb_fire) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (drtomem_wb_mask[b]) store[wb_idx][8*b +: 8] <= wb_line[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_ent[i] <= '0;
        q_tmr[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      retry_q <= 1'b1;
      nid_q   <= '0;
      ack_q   <= '0;
    end else begin
      retry_q <= 1'b0;
      nid_q   <= NID_W'(MEM_NID);
      ack_q   <= ACK_W'(ACK_VAL);
      // Every slot counts down, so entries behind a stalled head become ready in the background.
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_tmr[i] != '0) q_tmr[i] <= q_tmr[i] - TMR_W'(1);
      end
      if (req_fire) begin
        q_ent[wr_ptr] <= push_ent;
        q_tmr[wr_ptr] <= TMR_W'(LATENCY - 1);
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (ack_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == CNT_W'(QDEPTH));
    end
  end

  assign memtodr_ack_drid   = head.drid;
  assign memtodr_ack_paddr  = head.paddr;
  assign memtodr_ack_nid    = nid_q;
  assign memtodr_ack_ack    = ack_q;
  assign memtodr_ack_line_0 = head.line[0*LINE_W +: LINE_W];
  assign memtodr_ack_line_1 = head.line[1*LINE_W +: LINE_W];
  assign memtodr_ack_line_2 = head.line[2*LINE_W +: LINE_W];
  assign memtodr_ack_line_3 = head.line[3*LINE_W +: LINE_W];
  assign memtodr_ack_line_4 = head.line[4*LINE_W +: LINE_W];
  assign memtodr_ack_line_5 = head.line[5*LINE_W +: LINE_W];
  assign memtodr_ack_line_6 = head.line[6*LINE_W +: LINE_W];
  assign memtodr_ack_line_7 = head.line[7*LINE_W +: LINE_W];

  // Prefetches are accepted and dropped; command is irrelevant since every request is a read.
  assign unused_inputs = ^{drtomem_req_cmd, drtomem_pfreq_valid, drtomem_pfreq_nid,
                           drtomem_pfreq_paddr, drtomem_wb_paddr};

endmodule

// File: tb/tb_mem_responder.sv
// Directed and random bench for mem_responder against a queue/array reference model.
module tb_mem_responder;
  localparam int LATENCY = 4;
  localparam int QDEPTH  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         drtomem_req_valid;
  logic [5:0]   drtomem_req_drid;
  logic [4:0]   drtomem_req_cmd;
  logic [49:0]  drtomem_req_paddr;
  logic         memtodr_ack_retry;
  logic         drtomem_wb_valid;
  logic [511:0] wb_line;
  logic [63:0]  drtomem_wb_mask;
  logic [49:0]  drtomem_wb_paddr;
  logic         drtomem_pfreq_valid;
  logic [4:0]   drtomem_pfreq_nid;
  logic [49:0]  drtomem_pfreq_paddr;

  wire          drtomem_req_retry, memtodr_ack_valid, drtomem_wb_retry, drtomem_pfreq_retry;
  wire  [5:0]   memtodr_ack_drid;
  wire  [4:0]   memtodr_ack_nid;
  wire  [49:0]  memtodr_ack_paddr;
  wire  [2:0]   memtodr_ack_ack;
  wire  [511:0] ack_line;

  mem_responder #(.LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .drtomem_req_valid(drtomem_req_valid), .drtomem_req_retry(drtomem_req_retry),
    .drtomem_req_drid(drtomem_req_drid), .drtomem_req_cmd(drtomem_req_cmd),
    .drtomem_req_paddr(drtomem_req_paddr),
    .memtodr_ack_valid(memtodr_ack_valid), .memtodr_ack_retry(memtodr_ack_retry),
    .memtodr_ack_drid(memtodr_ack_drid), .memtodr_ack_nid(memtodr_ack_nid),
    .memtodr_ack_paddr(memtodr_ack_paddr), .memtodr_ack_ack(memtodr_ack_ack),
    .memtodr_ack_line_7(ack_line[511:448]), .memtodr_ack_line_6(ack_line[447:384]),
    .memtodr_ack_line_5(ack_line[383:320]), .memtodr_ack_line_4(ack_line[319:256]),
    .memtodr_ack_line_3(ack_line[255:192]), .memtodr_ack_line_2(ack_line[191:128]),
    .memtodr_ack_line_1(ack_line[127:64]),  .memtodr_ack_line_0(ack_line[63:0]),
    .drtomem_wb_valid(drtomem_wb_valid), .drtomem_wb_retry(drtomem_wb_retry),
    .drtomem_wb_line_7(wb_line[511:448]), .drtomem_wb_line_6(wb_line[447:384]),
    .drtomem_wb_line_5(wb_line[383:320]), .drtomem_wb_line_4(wb_line[319:256]),
    .drtomem_wb_line_3(wb_line[255:192]), .drtomem_wb_line_2(wb_line[191:128]),
    .drtomem_wb_line_1(wb_line[127:64]),  .drtomem_wb_line_0(wb_line[63:0]),
    .drtomem_wb_mask(drtomem_wb_mask), .drtomem_wb_paddr(drtomem_wb_paddr),
    .drtomem_pfreq_valid(drtomem_pfreq_valid), .drtomem_pfreq_retry(drtomem_pfreq_retry),
    .drtomem_pfreq_nid(drtomem_pfreq_nid), .drtomem_pfreq_paddr(drtomem_pfreq_paddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   drid;
    logic [49:0]  paddr;
    logic [511:0] line;
    int           rdy;
  } exp_t;

  logic [511:0] mstore [16];
  exp_t         mq [$];
  int           ack_drid_log [$];
  int           ack_cyc_log [$];
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  bit           req_fired, wb_fired, pf_fired;

  function automatic logic [3:0] idx(input logic [49:0] p);
    return p[9:6];
  endfunction

  function automatic logic [49:0] rnd_paddr();
    logic [49:0] p;
    p = {18'($urandom), 32'($urandom)};
    p[9:8] = 2'b00;
    return p;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: compare against the model, predict transfers, advance model, release fired senders.
  task automatic tick();
    bit mv, rf, wf, pf, pop;
    exp_t e;
    #1;
    mv = (mq.size() > 0) && (mq[0].rdy <= cyc);
    chk("ack_valid", memtodr_ack_valid, mv);
    if (mv) begin
      chk("ack_drid", memtodr_ack_drid, mq[0].drid);
      chk("ack_paddr", memtodr_ack_paddr, mq[0].paddr);
      chk("ack_line", ack_line, mq[0].line);
      chk("ack_nid", memtodr_ack_nid, 5'd0);
      chk("ack_ack", memtodr_ack_ack, 3'd0);
    end
    chk("req_retry", drtomem_req_retry, (mq.size() == QDEPTH) || drtomem_wb_valid);
    chk("wb_retry", drtomem_wb_retry, 1'b0);
    chk("pf_retry", drtomem_pfreq_retry, 1'b0);
    wf  = drtomem_wb_valid;
    rf  = drtomem_req_valid && (mq.size() != QDEPTH) && !drtomem_wb_valid;
    pf  = drtomem_pfreq_valid;
    pop = mv && !memtodr_ack_retry;
    @(posedge clk);
    if (pop) begin
      ack_drid_log.push_back(int'(mq[0].drid));
      ack_cyc_log.push_back(cyc);
      void'(mq.pop_front());
    end
    if (rf) begin
      e.drid  = drtomem_req_drid;
      e.paddr = drtomem_req_paddr;
      e.line  = mstore[idx(drtomem_req_paddr)];
      e.rdy   = cyc + LATENCY;
      mq.push_back(e);
    end
    if (wf) begin
      for (int b = 0; b < 64; b++)
        if (drtomem_wb_mask[b]) mstore[idx(drtomem_wb_paddr)][8*b +: 8] = wb_line[8*b +: 8];
    end
    req_fired = rf; wb_fired = wf; pf_fired = pf;
    cyc++;
    @(negedge clk);
    if (rf) drtomem_req_valid = 1'b0;
    if (wf) drtomem_wb_valid = 1'b0;
    if (pf) drtomem_pfreq_valid = 1'b0;
  endtask

  task automatic send_req(input logic [5:0] d, input logic [49:0] p);
    int n;
    n = 0;
    drtomem_req_valid = 1'b1; drtomem_req_drid = d; drtomem_req_paddr = p;
    drtomem_req_cmd = 5'($urandom);
    do begin tick(); n++; end while (!req_fired && n < 64);
    chk("req_accept_bound", req_fired, 1'b1);
    drtomem_req_valid = 1'b0;
  endtask

  task automatic send_wb(input logic [49:0] p, input logic [63:0] m, input logic [511:0] l);
    drtomem_wb_valid = 1'b1; drtomem_wb_paddr = p; drtomem_wb_mask = m; wb_line = l;
    tick();
    chk("wb_accept", wb_fired, 1'b1);
    drtomem_wb_valid = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!memtodr_ack_valid && n < 32) begin tick(); n++; end
    chk("ack_seen_bound", memtodr_ack_valid, 1'b1);
  endtask

  task automatic do_reset();
    drtomem_req_valid = 1'b0; drtomem_wb_valid = 1'b0; drtomem_pfreq_valid = 1'b0;
    memtodr_ack_retry = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ack_valid", memtodr_ack_valid, 1'b0);
    chk("rst_req_retry", drtomem_req_retry, 1'b1);
    chk("rst_wb_retry", drtomem_wb_retry, 1'b1);
    chk("rst_pf_retry", drtomem_pfreq_retry, 1'b1);
    chk("rst_ack_drid", memtodr_ack_drid, 6'd0);
    chk("rst_ack_paddr", memtodr_ack_paddr, 50'd0);
    chk("rst_ack_line", ack_line, 512'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    for (int i = 0; i < 16; i++) mstore[i] = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, seen;
    logic [511:0] l;
    reset = 1'b0;
    drtomem_req_valid = 1'b0; drtomem_req_drid = '0; drtomem_req_cmd = '0; drtomem_req_paddr = '0;
    memtodr_ack_retry = 1'b0;
    drtomem_wb_valid = 1'b0; wb_line = '0; drtomem_wb_mask = '0; drtomem_wb_paddr = '0;
    drtomem_pfreq_valid = 1'b0; drtomem_pfreq_nid = '0; drtomem_pfreq_paddr = '0;
    @(negedge clk);
    do_reset();

    // Write then read.
    l = '0; l[63:0] = 64'h1122334455667788;
    send_wb(50'h0C0, {64{1'b1}}, l);
    send_req(6'd5, 50'h0C0);
    wait_ack(n);
    chk("wr_rd_latency", n, LATENCY - 1);
    chk("wr_rd_drid", memtodr_ack_drid, 6'd5);
    chk("wr_rd_paddr", memtodr_ack_paddr, 50'h0C0);
    chk("wr_rd_line0", ack_line[63:0], 64'h1122334455667788);
    chk("wr_rd_nid", memtodr_ack_nid, 5'd0);
    tick();

    // Partial mask.
    l = '0; l[63:0] = 64'hFF;
    send_wb(50'h0C0, 64'h1, l);
    send_req(6'd6, 50'h0C0);
    wait_ack(n);
    chk("partial_line0", ack_line[63:0], 64'h11223344556677FF);
    tick();

    // Writeback and request colliding in one cycle.
    l = '0; l[63:0] = 64'hAA00;
    drtomem_wb_valid = 1'b1; drtomem_wb_paddr = 50'h0C0; drtomem_wb_mask = 64'h2; wb_line = l;
    drtomem_req_valid = 1'b1; drtomem_req_drid = 6'd7; drtomem_req_paddr = 50'h0C0;
    tick();
    chk("collide_req_blocked", req_fired, 1'b0);
    chk("collide_wb_taken", wb_fired, 1'b1);
    tick();
    chk("collide_req_next", req_fired, 1'b1);
    wait_ack(n);
    chk("collide_line0", ack_line[63:0], 64'h112233445566AAFF);
    tick();

    // Full queue under ack backpressure.
    memtodr_ack_retry = 1'b1;
    for (int d = 1; d <= 4; d++) send_req(6'(d), 50'(64 * d + 50'h400));
    drtomem_req_valid = 1'b1; drtomem_req_drid = 6'd5; drtomem_req_paddr = 50'h540;
    tick();
    chk("full_5th_retried", req_fired, 1'b0);
    repeat (LATENCY + 1) tick();
    chk("full_hold_valid", memtodr_ack_valid, 1'b1);
    chk("full_hold_drid_a", memtodr_ack_drid, 6'd1);
    repeat (2) tick();
    chk("full_hold_drid_b", memtodr_ack_drid, 6'd1);
    ack_drid_log.delete(); ack_cyc_log.delete();
    memtodr_ack_retry = 1'b0;
    n = 0;
    while (ack_drid_log.size() < 5 && n < 40) begin tick(); n++; end
    chk("full_ack_count", ack_drid_log.size(), 5);
    for (int i = 0; i < ack_drid_log.size(); i++) chk("full_ack_order", ack_drid_log[i], i + 1);
    for (int i = 1; i < 4 && i < ack_cyc_log.size(); i++)
      chk("full_ack_b2b", ack_cyc_log[i] - ack_cyc_log[0], i);

    // Prefetches are accepted and leave no trace.
    for (int k = 0; k < 3; k++) begin
      drtomem_pfreq_valid = 1'b1; drtomem_pfreq_nid = 5'($urandom);
      drtomem_pfreq_paddr = (k == 0) ? 50'h0C0 : rnd_paddr();
      tick();
      chk("pf_accept", pf_fired, 1'b1);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (memtodr_ack_valid) seen++;
      tick();
    end
    chk("pf_no_ack", seen, 0);
    send_req(6'd8, 50'h0C0);
    wait_ack(n);
    chk("pf_store_same", ack_line[63:0], 64'h112233445566AAFF);
    tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if (!drtomem_req_valid && $urandom_range(0, 2) == 0) begin
        drtomem_req_valid = 1'b1; drtomem_req_drid = 6'($urandom);
        drtomem_req_cmd = 5'($urandom); drtomem_req_paddr = rnd_paddr();
      end
      if (!drtomem_wb_valid && $urandom_range(0, 3) == 0) begin
        drtomem_wb_valid = 1'b1; wb_line = rnd_line(); drtomem_wb_paddr = rnd_paddr();
        drtomem_wb_mask = {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 5) == 0) drtomem_wb_mask = '0;
      end
      if (!drtomem_pfreq_valid && $urandom_range(0, 4) == 0) begin
        drtomem_pfreq_valid = 1'b1; drtomem_pfreq_nid = 5'($urandom);
        drtomem_pfreq_paddr = rnd_paddr();
      end
      memtodr_ack_retry = ($urandom_range(0, 3) == 0);
      tick();
    end
    drtomem_req_valid = 1'b0; drtomem_wb_valid = 1'b0; drtomem_pfreq_valid = 1'b0;
    memtodr_ack_retry = 1'b0;
    repeat (24) tick();

    // Reset with requests outstanding.
    send_wb(50'h140, {64{1'b1}}, rnd_line());
    memtodr_ack_retry = 1'b1;
    send_req(6'd9, 50'h140);
    send_req(6'd10, 50'h180);
    do_reset();
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (memtodr_ack_valid) seen++;
      tick();
    end
    chk("rst_no_ack_after", seen, 0);
    send_req(6'd11, 50'h140);
    wait_ack(n);
    chk("rst_store_cleared", ack_line, 512'd0);
    chk("rst_read_drid", memtodr_ack_drid, 6'd11);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
